// File: rtl/mc_ctrl_gen2_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_gen2_pkg
// Shared definitions for the multicycle controller: FSM state encoding,
// instruction field layout, data-processing command codes, ALUControl codes,
// and the select encodings for ALUSrcA / ALUSrcB / ResultSrc.
// ----------------------------------------------------------------------------
package mc_ctrl_gen2_pkg;

    // FSM states
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXECR  = 4'd2,
        S_EXECI  = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    // Instruction bits [31:12] as presented on the Instr port
    typedef struct packed {
        logic [3:0] cond;   // [31:28]
        logic [1:0] op;     // [27:26]
        logic [5:0] funct;  // [25:20]  I, cmd[3:0], S (or L for memory ops)
        logic [3:0] rn;     // [19:16]
        logic [3:0] rd;     // [15:12]
    } instr_t;

    // Op field
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Condition codes with special meaning
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Data-processing commands (Funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // ALUControl codes (low three bits; wider ALUControl is zero-extended)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    // ALUSrcA selects
    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Result of decoding a data-processing command
    typedef struct packed {
        logic       valid;
        logic [2:0] alu;
    } cmd_dec_t;

    function automatic cmd_dec_t cmd_decode(input logic [3:0] cmd);
        cmd_dec_t d;
        d.valid = 1'b1;
        d.alu   = ALU_ADD;
        case (cmd)
            CMD_AND: d.alu = ALU_AND;
            CMD_EOR: d.alu = ALU_EOR;
            CMD_SUB: d.alu = ALU_SUB;
            CMD_ADD: d.alu = ALU_ADD;
            CMD_TST: d.alu = ALU_AND;
            CMD_CMP: d.alu = ALU_SUB;
            CMD_ORR: d.alu = ALU_ORR;
            CMD_MOV: d.alu = ALU_MOV;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_ctrl_gen2_if.sv
// ----------------------------------------------------------------------------
// mc_ctrl_gen2_if
// Controller <-> datapath/memory bundle.
//   master : the controller (reads Instr/ALUFlags/MemReady, drives controls)
//   slave  : the datapath / memory side
// Signals:
//   Instr[19:0]   instruction bits [31:12]
//   ALUFlags[3:0] {N,Z,C,V} from the ALU
//   MemReady      memory has completed the current access
//   MemReq        memory access request
//   PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc   enables and address select
//   RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc    2-bit datapath selects
//   ALUControl    ALU operation, ALUCTRL_W bits (ALUCTRL_W >= 3)
//   Undef         sticky undefined-instruction trap
// ----------------------------------------------------------------------------
interface mc_ctrl_gen2_if #(
    parameter int ALUCTRL_W = 3
);
    logic [19:0]          Instr;
    logic [3:0]           ALUFlags;
    logic                 MemReady;
    logic                 MemReq;
    logic                 PCWrite;
    logic                 MemWrite;
    logic                 RegWrite;
    logic                 IRWrite;
    logic                 AdrSrc;
    logic [1:0]           RegSrc;
    logic [1:0]           ImmSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ResultSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 Undef;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output MemReq, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
               RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Undef
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  MemReq, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
               RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Undef
    );
endinterface

// File: rtl/mc_ctrl_gen2_condcheck.sv
// ----------------------------------------------------------------------------
// mc_condcheck
// Combinational condition evaluation.
//   cond[3:0]   instruction condition field
//   flags[3:0]  stored {N,Z,C,V}
//   cond_ex     condition passes
//   cond_undef  condition field is the reserved 1111 encoding
// ----------------------------------------------------------------------------
import mc_ctrl_gen2_pkg::*;

module mc_condcheck (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex,
    output logic       cond_undef
);
    logic n, z, c, v, ge;

    assign {n, z, c, v} = flags;
    assign ge           = (n == v);
    assign cond_undef   = (cond == COND_NV);

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = ge;
            4'b1011: cond_ex = ~ge;
            4'b1100: cond_ex = ~z & ge;
            4'b1101: cond_ex = z | ~ge;
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;   // NV never executes; it traps instead
        endcase
    end
endmodule

// File: rtl/mc_ctrl_gen2.sv
// ----------------------------------------------------------------------------
// mc_ctrl_gen2
// Multicycle ARM-subset main controller with memory handshake and an
// undefined-instruction trap.
// Ports:
//   clk     clock, rising edge
//   reset   asynchronous, active-low
//   bus     mc_ctrl_gen2_if.master (instruction/flags/MemReady in, controls out)
// Parameters:
//   ALUCTRL_W  ALUControl width (>= 3); upper bits are always 0
//   MEM_HS     1: FETCH/MEMRD/MEMWR wait for MemReady; 0: MemReady taken as 1
// ----------------------------------------------------------------------------
import mc_ctrl_gen2_pkg::*;

module mc_ctrl_gen2 #(
    parameter int ALUCTRL_W = 3,
    parameter int MEM_HS    = 1
) (
    input  logic               clk,
    input  logic               reset,
    mc_ctrl_gen2_if.master     bus
);
    state_t     state, next_state;
    instr_t     instr;
    cmd_dec_t   dp;
    logic [3:0] flags;
    logic       undef;
    logic       mem_ready;
    logic       cond_ex, cond_undef;
    logic       is_test, is_cmp, is_arith, s_bit, rd_pc;
    logic       nz_load, cv_load;

    // Datapath-facing outputs, built in the output process
    logic       mem_req, pc_write, mem_write, reg_write, ir_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, reg_src;
    logic [2:0] alu_ctrl;

    assign instr     = instr_t'(bus.Instr);
    assign mem_ready = (MEM_HS != 0) ? bus.MemReady : 1'b1;

    assign dp       = cmd_decode(instr.funct[4:1]);
    assign s_bit    = instr.funct[0];
    assign is_cmp   = (instr.funct[4:1] == CMD_CMP);
    assign is_test  = (instr.funct[4:1] == CMD_TST) || is_cmp;
    assign is_arith = (instr.funct[4:1] == CMD_ADD) || (instr.funct[4:1] == CMD_SUB) || is_cmp;
    assign rd_pc    = (instr.rd == 4'd15);

    // Logical ops only touch N/Z; C/V come from the adder, so they load only
    // for flag-setting arithmetic.
    assign nz_load = s_bit || is_test;
    assign cv_load = (s_bit || is_cmp) && is_arith;

    mc_condcheck u_condcheck (
        .cond       (instr.cond),
        .flags      (flags),
        .cond_ex    (cond_ex),
        .cond_undef (cond_undef)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= next_state;
    end

    // Stored flags change only at the end of an EXEC cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else if (state == S_EXECR || state == S_EXECI) begin
            if (nz_load) flags[3:2] <= bus.ALUFlags[3:2];
            if (cv_load) flags[1:0] <= bus.ALUFlags[1:0];
        end
    end

    // Sticky trap indicator: set on the edge that enters TRAP, so it is high
    // for every cycle spent in TRAP and cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    undef <= 1'b0;
        else if (next_state == S_TRAP) undef <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                if (cond_undef)    next_state = S_TRAP;
                else if (!cond_ex) next_state = S_FETCH;
                else begin
                    case (instr.op)
                        OP_DP:   next_state = !dp.valid       ? S_TRAP  :
                                              instr.funct[5]  ? S_EXECI : S_EXECR;
                        OP_MEM:  next_state = S_MEMADR;
                        OP_BR:   next_state = S_BRANCH;
                        default: next_state = S_TRAP;
                    endcase
                end
            end
            S_EXECR,
            S_EXECI:  next_state = is_test ? S_FETCH : S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_MEMADR: next_state = instr.funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:  next_state = S_FETCH;
            S_MEMWR:  if (mem_ready) next_state = S_FETCH;
            S_BRANCH: next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        result_src = RES_ALUOUT;
        alu_ctrl   = ALU_ADD;

        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                // IR and PC update once, on the cycle the fetch completes
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_PC;     // PC+4 again -> PC+8
                alu_src_b = SRCB_FOUR;
            end
            S_EXECR: alu_ctrl = dp.alu;
            S_EXECI: begin
                alu_src_b = SRCB_IMM;
                alu_ctrl  = dp.alu;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                pc_write   = rd_pc;
                reg_write  = !rd_pc;
            end
            S_MEMADR: alu_src_b = SRCB_IMM;
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                pc_write   = rd_pc;
                reg_write  = !rd_pc;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_ALUOUT;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_write   = 1'b1;
            end
            default: ;                   // TRAP: everything stays inactive
        endcase

        // Reset overrides the FETCH state's request so nothing reaches the
        // memory or register file while reset is held low.
        if (!reset) begin
            mem_req   = 1'b0;
            pc_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            ir_write  = 1'b0;
        end
    end

    // Decode fields are a pure function of Op and hold in every state
    always_comb begin
        reg_src = 2'b00;
        case (instr.op)
            OP_MEM:  reg_src = 2'b10;
            OP_BR:   reg_src = 2'b01;
            default: reg_src = 2'b00;
        endcase
    end

    assign bus.MemReq     = mem_req;
    assign bus.PCWrite    = pc_write;
    assign bus.MemWrite   = mem_write;
    assign bus.RegWrite   = reg_write;
    assign bus.IRWrite    = ir_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.RegSrc     = reg_src;
    assign bus.ImmSrc     = instr.op;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = ALUCTRL_W'(alu_ctrl);
    assign bus.Undef      = undef;

endmodule

// File: tb/tb_mc_ctrl_gen2.sv
// ----------------------------------------------------------------------------
// tb_mc_ctrl_gen2
// Directed self-checking bench for mc_ctrl_gen2. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
// Enable vector order used throughout:
//   {MemReq, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc}
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
import mc_ctrl_gen2_pkg::*;

module tb_mc_ctrl_gen2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mc_ctrl_gen2_if #(.ALUCTRL_W(3)) bus  ();
    mc_ctrl_gen2_if #(.ALUCTRL_W(3)) bus0 ();

    mc_ctrl_gen2 #(.ALUCTRL_W(3), .MEM_HS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mc_ctrl_gen2 #(.ALUCTRL_W(3), .MEM_HS(0)) dut_nohs (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    // Instruction bits [31:12]: {cond, op, funct, rn, rd}
    localparam logic [19:0] I_ADDS   = {4'b1110, 2'b00, 6'b001001, 4'd2, 4'd1};
    localparam logic [19:0] I_LDR_PC = {4'b1110, 2'b01, 6'b011001, 4'd0, 4'd15};
    localparam logic [19:0] I_STR    = {4'b1110, 2'b01, 6'b011000, 4'd0, 4'd2};
    localparam logic [19:0] I_BEQ    = {4'b0000, 2'b10, 6'b100000, 4'd0, 4'd0};
    localparam logic [19:0] I_BAL    = {4'b1110, 2'b10, 6'b100000, 4'd0, 4'd0};
    localparam logic [19:0] I_CMP    = {4'b1110, 2'b00, 6'b110101, 4'd1, 4'd0};
    localparam logic [19:0] I_MOVNE  = {4'b0001, 2'b00, 6'b011010, 4'd0, 4'd3};
    localparam logic [19:0] I_TST    = {4'b1110, 2'b00, 6'b010000, 4'd1, 4'd0};
    localparam logic [19:0] I_ORR_PC = {4'b1110, 2'b00, 6'b011000, 4'd1, 4'd15};
    localparam logic [19:0] I_NV     = {4'b1111, 2'b00, 6'b001000, 4'd1, 4'd2};
    localparam logic [19:0] I_OP11   = {4'b1110, 2'b11, 6'b000000, 4'd0, 4'd0};

    localparam logic [5:0] EN_NONE   = 6'b000000;
    localparam logic [5:0] EN_FETCH  = 6'b110010;  // MemReq, PCWrite, IRWrite
    localparam logic [5:0] EN_FWAIT  = 6'b100000;  // fetch with MemReady low
    localparam logic [5:0] EN_REGW   = 6'b000100;
    localparam logic [5:0] EN_PCW    = 6'b010000;
    localparam logic [5:0] EN_MEMRD  = 6'b100001;
    localparam logic [5:0] EN_MEMWR  = 6'b101001;

    function automatic logic [5:0] en_now();
        return {bus.MemReq, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT just out of reset, 1 ns after a rising edge, in FETCH
    task automatic apply_reset();
        reset = 1'b0;
        bus.MemReady = 1'b1;
        bus.ALUFlags = 4'b0000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        bus.Instr = I_ADDS;
        bus.MemReady = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dut.state !== S_FETCH) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state, S_FETCH);
        end
        n_tests++;
        if (en_now() !== EN_NONE || dut.flags !== 4'b0000 || bus.Undef !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: en=%b flags=%b undef=%b want en=000000 flags=0000 undef=0",
                               en_now(), dut.flags, bus.Undef);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dut.state !== S_FETCH || en_now() !== EN_FETCH) begin
            n_fail++; $display("FAIL reset_release: state=%0d en=%b want state=%0d en=%b",
                               dut.state, en_now(), S_FETCH, EN_FETCH);
        end
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_adds();
        state_t     exp_st [0:4];
        logic [5:0] exp_en [0:4];
        exp_st = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
        exp_en = '{EN_FETCH, EN_NONE, EN_NONE, EN_REGW, EN_FETCH};
        apply_reset();
        bus.Instr    = I_ADDS;
        bus.ALUFlags = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (dut.state !== exp_st[i] || en_now() !== exp_en[i]) begin
                n_fail++; $display("FAIL adds[%0d]: state=%0d en=%b want state=%0d en=%b",
                                   i, dut.state, en_now(), exp_st[i], exp_en[i]);
            end
            if (i == 1) begin
                n_tests++;
                if (dut.flags !== 4'b0000) begin
                    n_fail++; $display("FAIL adds_flags_decode: got %b want 0000", dut.flags);
                end
            end
            if (i == 2) begin
                n_tests++;
                if (bus.ALUControl !== 3'b000 || bus.ALUSrcA !== 2'b00 || bus.ALUSrcB !== 2'b00) begin
                    n_fail++; $display("FAIL adds_execr: alu=%b srca=%b srcb=%b want 000 00 00",
                                       bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB);
                end
            end
            if (i == 3) begin
                n_tests++;
                if (dut.flags !== 4'b0110 || bus.ResultSrc !== 2'b00) begin
                    n_fail++; $display("FAIL adds_aluwb: flags=%b ressrc=%b want 0110 00",
                                       dut.flags, bus.ResultSrc);
                end
            end
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_ldr_stall();
        state_t     exp_st [0:8];
        logic [5:0] exp_en [0:8];
        logic       mr     [0:8];
        int         n_mem, n_pcw;
        exp_st = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB, S_FETCH};
        exp_en = '{EN_FETCH, EN_NONE, EN_NONE, EN_MEMRD, EN_MEMRD, EN_MEMRD, EN_MEMRD, EN_PCW, EN_FETCH};
        mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        n_mem = 0;
        n_pcw = 0;
        apply_reset();
        bus.Instr = I_LDR_PC;
        for (int i = 0; i < 9; i++) begin
            bus.MemReady = mr[i];
            @(negedge clk);
            n_tests++;
            if (dut.state !== exp_st[i] || en_now() !== exp_en[i]) begin
                n_fail++; $display("FAIL ldr[%0d]: state=%0d en=%b want state=%0d en=%b",
                                   i, dut.state, en_now(), exp_st[i], exp_en[i]);
            end
            if (i >= 1 && i <= 7) begin
                if (bus.MemReq && bus.AdrSrc) n_mem++;
                if (bus.PCWrite) n_pcw++;
            end
            if (i == 2) begin
                n_tests++;
                if (bus.ALUSrcA !== 2'b00 || bus.ALUSrcB !== 2'b01 || bus.ImmSrc !== 2'b01 || bus.RegSrc !== 2'b10) begin
                    n_fail++; $display("FAIL ldr_memadr: srca=%b srcb=%b imm=%b regsrc=%b want 00 01 01 10",
                                       bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc);
                end
            end
            if (i == 7) begin
                n_tests++;
                if (bus.ResultSrc !== 2'b01) begin
                    n_fail++; $display("FAIL ldr_memwb_ressrc: got %b want 01", bus.ResultSrc);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (n_mem !== 4) begin
            n_fail++; $display("FAIL ldr_access_cycles: got %0d want 4", n_mem);
        end
        n_tests++;
        if (n_pcw !== 1) begin
            n_fail++; $display("FAIL ldr_pcwrite_count: got %0d want 1", n_pcw);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_str_reset();
        state_t     exp_st [0:4];
        logic [5:0] exp_en [0:4];
        logic       mr     [0:4];
        exp_st = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR};
        exp_en = '{EN_FETCH, EN_NONE, EN_NONE, EN_MEMWR, EN_MEMWR};
        mr     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        apply_reset();
        bus.Instr = I_STR;
        for (int i = 0; i < 5; i++) begin
            bus.MemReady = mr[i];
            @(negedge clk);
            n_tests++;
            if (dut.state !== exp_st[i] || en_now() !== exp_en[i]) begin
                n_fail++; $display("FAIL str[%0d]: state=%0d en=%b want state=%0d en=%b",
                                   i, dut.state, en_now(), exp_st[i], exp_en[i]);
            end
            if (i < 4) next_cycle();
        end
        // Pull reset mid-write, away from any clock edge
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (bus.MemWrite !== 1'b0 || bus.MemReq !== 1'b0 || dut.state !== S_FETCH) begin
            n_fail++; $display("FAIL str_reset_abort: memwrite=%b memreq=%b state=%0d want 0 0 %0d",
                               bus.MemWrite, bus.MemReq, dut.state, S_FETCH);
        end
        next_cycle();
        reset = 1'b1;
        bus.MemReady = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dut.state !== S_FETCH || en_now() !== EN_FETCH) begin
            n_fail++; $display("FAIL str_after_release: state=%0d en=%b want %0d %b",
                               dut.state, en_now(), S_FETCH, EN_FETCH);
        end
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_branch();
        state_t      exp_st [0:5];
        logic [5:0]  exp_en [0:5];
        logic [19:0] ins    [0:5];
        exp_st = '{S_FETCH, S_DECODE, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        exp_en = '{EN_FETCH, EN_NONE, EN_FETCH, EN_NONE, EN_PCW, EN_FETCH};
        ins    = '{I_BEQ, I_BEQ, I_BAL, I_BAL, I_BAL, I_BAL};
        apply_reset();   // flags 0000: Z=0, so BEQ is not taken
        for (int i = 0; i < 6; i++) begin
            bus.Instr = ins[i];
            @(negedge clk);
            n_tests++;
            if (dut.state !== exp_st[i] || en_now() !== exp_en[i]) begin
                n_fail++; $display("FAIL branch[%0d]: state=%0d en=%b want state=%0d en=%b",
                                   i, dut.state, en_now(), exp_st[i], exp_en[i]);
            end
            if (i == 4) begin
                n_tests++;
                if (bus.ALUSrcA !== 2'b10 || bus.ALUSrcB !== 2'b01 || bus.ResultSrc !== 2'b10 ||
                    bus.ALUControl !== 3'b000 || bus.RegSrc !== 2'b01 || bus.ImmSrc !== 2'b10) begin
                    n_fail++; $display("FAIL branch_selects: srca=%b srcb=%b res=%b alu=%b regsrc=%b imm=%b want 10 01 10 000 01 10",
                                       bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl, bus.RegSrc, bus.ImmSrc);
                end
            end
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_cmp_movne();
        state_t      exp_st [0:5];
        logic [5:0]  exp_en [0:5];
        logic [19:0] ins    [0:5];
        logic [3:0]  alu_in [0:5];
        exp_st = '{S_FETCH, S_DECODE, S_EXECI, S_FETCH, S_DECODE, S_FETCH};
        exp_en = '{EN_FETCH, EN_NONE, EN_NONE, EN_FETCH, EN_NONE, EN_FETCH};
        ins    = '{I_CMP, I_CMP, I_CMP, I_MOVNE, I_MOVNE, I_MOVNE};
        alu_in = '{4'b0110, 4'b0110, 4'b0110, 4'b0000, 4'b0000, 4'b0000};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            bus.Instr    = ins[i];
            bus.ALUFlags = alu_in[i];
            @(negedge clk);
            n_tests++;
            if (dut.state !== exp_st[i] || en_now() !== exp_en[i]) begin
                n_fail++; $display("FAIL cmp_movne[%0d]: state=%0d en=%b want state=%0d en=%b",
                                   i, dut.state, en_now(), exp_st[i], exp_en[i]);
            end
            if (i == 2) begin
                n_tests++;
                if (bus.ALUControl !== 3'b001 || bus.ALUSrcA !== 2'b00 || bus.ALUSrcB !== 2'b01) begin
                    n_fail++; $display("FAIL cmp_execi: alu=%b srca=%b srcb=%b want 001 00 01",
                                       bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB);
                end
            end
            if (i == 3 || i == 5) begin
                n_tests++;
                if (dut.flags !== 4'b0110) begin
                    n_fail++; $display("FAIL cmp_flags[%0d]: got %b want 0110", i, dut.flags);
                end
            end
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_tst_orr();
        state_t      exp_st [0:7];
        logic [5:0]  exp_en [0:7];
        logic [19:0] ins    [0:7];
        logic [3:0]  alu_in [0:7];
        exp_st = '{S_FETCH, S_DECODE, S_EXECR, S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
        exp_en = '{EN_FETCH, EN_NONE, EN_NONE, EN_FETCH, EN_NONE, EN_NONE, EN_PCW, EN_FETCH};
        ins    = '{I_TST, I_TST, I_TST, I_ORR_PC, I_ORR_PC, I_ORR_PC, I_ORR_PC, I_ORR_PC};
        alu_in = '{4'b1111, 4'b1111, 4'b1111, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            bus.Instr    = ins[i];
            bus.ALUFlags = alu_in[i];
            @(negedge clk);
            n_tests++;
            if (dut.state !== exp_st[i] || en_now() !== exp_en[i]) begin
                n_fail++; $display("FAIL tst_orr[%0d]: state=%0d en=%b want state=%0d en=%b",
                                   i, dut.state, en_now(), exp_st[i], exp_en[i]);
            end
            if (i == 2 || i == 5) begin
                n_tests++;
                if (bus.ALUControl !== ((i == 2) ? 3'b010 : 3'b011)) begin
                    n_fail++; $display("FAIL tst_orr_aluctrl[%0d]: got %b want %b",
                                       i, bus.ALUControl, (i == 2) ? 3'b010 : 3'b011);
                end
            end
            if (i == 3 || i == 7) begin
                // TST without S loads only N/Z; ORR without S loads nothing
                n_tests++;
                if (dut.flags !== 4'b1100) begin
                    n_fail++; $display("FAIL tst_orr_flags[%0d]: got %b want 1100", i, dut.flags);
                end
            end
            next_cycle();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_trap();
        apply_reset();
        bus.Instr = I_NV;
        @(negedge clk);
        n_tests++;
        if (dut.state !== S_FETCH || bus.Undef !== 1'b0) begin
            n_fail++; $display("FAIL trap_fetch: state=%0d undef=%b want %0d 0", dut.state, bus.Undef, S_FETCH);
        end
        next_cycle();
        next_cycle();      // DECODE -> TRAP
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (dut.state !== S_TRAP || {bus.Undef, en_now()} !== 7'b1000000) begin
                n_fail++; $display("FAIL trap_hold[%0d]: state=%0d undef=%b en=%b want %0d 1 000000",
                                   i, dut.state, bus.Undef, en_now(), S_TRAP);
            end
            next_cycle();
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.Undef !== 1'b0 || dut.state !== S_FETCH) begin
            n_fail++; $display("FAIL trap_reset: undef=%b state=%0d want 0 %0d", bus.Undef, dut.state, S_FETCH);
        end
        next_cycle();
        reset = 1'b1;
        bus.Instr = I_OP11;
        @(negedge clk);
        n_tests++;
        if (dut.state !== S_FETCH || bus.Undef !== 1'b0 || en_now() !== EN_FETCH) begin
            n_fail++; $display("FAIL trap_release: state=%0d undef=%b en=%b want %0d 0 %b",
                               dut.state, bus.Undef, en_now(), S_FETCH, EN_FETCH);
        end
        next_cycle();
        next_cycle();      // DECODE of Op=11 -> TRAP
        @(negedge clk);
        n_tests++;
        if (dut.state !== S_TRAP || bus.Undef !== 1'b1) begin
            n_fail++; $display("FAIL trap_op11: state=%0d undef=%b want %0d 1", dut.state, bus.Undef, S_TRAP);
        end
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_no_handshake();
        bus0.Instr    = I_ADDS;
        bus0.ALUFlags = 4'b0000;
        bus0.MemReady = 1'b0;
        apply_reset();
        @(negedge clk);
        n_tests++;
        if (dut_nohs.state !== S_FETCH || bus0.IRWrite !== 1'b1 || bus0.PCWrite !== 1'b1) begin
            n_fail++; $display("FAIL nohs_fetch: state=%0d irw=%b pcw=%b want %0d 1 1",
                               dut_nohs.state, bus0.IRWrite, bus0.PCWrite, S_FETCH);
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (dut_nohs.state !== S_DECODE) begin
            n_fail++; $display("FAIL nohs_decode: state=%0d want %0d", dut_nohs.state, S_DECODE);
        end
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    initial begin
        bus.Instr     = 20'd0;
        bus.ALUFlags  = 4'b0000;
        bus.MemReady  = 1'b1;
        bus0.Instr    = I_ADDS;
        bus0.ALUFlags = 4'b0000;
        bus0.MemReady = 1'b0;
        test_reset();
        test_adds();
        test_ldr_stall();
        test_str_reset();
        test_branch();
        test_cmp_movne();
        test_tst_orr();
        test_trap();
        test_no_handshake();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
